// File: rtl/spmv_pkg.sv
// spmv_pkg: shared types and constants for the SpMV multiply scheduler.
//   - sched_state_e : scheduler FSM states (IDLE, RUN, DRAIN, DONE)
//   - FP16_W        : fp16 operand/product width
//   - prod_entry_t  : tagged product {data, row, last} at the default row-tag width
//   - inflight_cnt  : number of occupied multiply pipeline stages (0..2)
package spmv_pkg;

  localparam int FP16_W    = 16;
  localparam int ROW_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [FP16_W-1:0]    data;
    logic [ROW_W_DEF-1:0] row;
    logic                 last;
  } prod_entry_t;

  function automatic logic [1:0] inflight_cnt(input logic s1_valid, input logic s2_valid);
    return {1'b0, s1_valid} + {1'b0, s2_valid};
  endfunction

endpackage

// File: rtl/spmv_mul_scheduler_if.sv
// spmv_mul_scheduler_if: bundle of the scheduler's data-path buses.
//   nnz_*  : CSR nonzero stream (valid/ready handshake)
//   vec_*  : synchronous-read dense-vector RAM port
//   mul_*  : operands to / result from the one-cycle fp16 multiplier
//   prod_* : tagged product stream to the row accumulator (valid/ready)
// Modports: slave = scheduler side, master = environment side.
interface spmv_mul_scheduler_if
  import spmv_pkg::*;
#(
  parameter int COL_W = 10,
  parameter int ROW_W = 12
);
  logic              nnz_valid;
  logic              nnz_ready;
  logic [FP16_W-1:0] nnz_value;
  logic [COL_W-1:0]  nnz_col;
  logic              nnz_last;

  logic              vec_rd_en;
  logic [COL_W-1:0]  vec_rd_addr;
  logic [FP16_W-1:0] vec_rd_data;

  logic [FP16_W-1:0] mul_vector;
  logic [FP16_W-1:0] mul_value;
  logic [FP16_W-1:0] mul_result;

  logic              prod_valid;
  logic              prod_ready;
  logic [FP16_W-1:0] prod_data;
  logic [ROW_W-1:0]  prod_row;
  logic              prod_last;

  modport slave (
    input  nnz_valid, nnz_value, nnz_col, nnz_last,
    output nnz_ready,
    output vec_rd_en, vec_rd_addr,
    input  vec_rd_data,
    output mul_vector, mul_value,
    input  mul_result,
    output prod_valid, prod_data, prod_row, prod_last,
    input  prod_ready
  );

  modport master (
    output nnz_valid, nnz_value, nnz_col, nnz_last,
    input  nnz_ready,
    input  vec_rd_en, vec_rd_addr,
    output vec_rd_data,
    input  mul_vector, mul_value,
    output mul_result,
    input  prod_valid, prod_data, prod_row, prod_last,
    output prod_ready
  );
endinterface

// File: rtl/spmv_prod_fifo.sv
// spmv_prod_fifo: synchronous FIFO holding tagged products.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   clr           : synchronous flush (pointers and count to zero)
//   push, din     : write request and entry (dropped only if full with no pop)
//   pop           : read request (ignored when empty)
//   dout, valid   : head entry (zero when empty) and non-empty flag
//   count         : current occupancy 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module spmv_prod_fifo
  import spmv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = prod_entry_t
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   clr,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_s, pop_ok_s, push_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    full_s    = (count_q == (PTR_W+1)'(DEPTH));
    pop_ok_s  = pop & (count_q != (PTR_W+1)'(0));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push_ok_s = push & (~full_s | pop_ok_s);
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != (PTR_W+1)'(0));
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/spmv_mul_scheduler.sv
// spmv_mul_scheduler: sequences CSR nonzeros through vector fetch and the
// external one-cycle fp16 multiplier, tagging each product with its row and
// buffering it for the row accumulator.
// Ports:
//   i_clk, i_rstn     : clock, asynchronous active-low reset
//   start, nnz_total  : begin a pass of nnz_total nonzeros (sampled in IDLE)
//   busy, done        : pass in progress (RUN/DRAIN); one-cycle completion pulse
//   bus (slave)       : nnz stream, vector RAM, multiplier and product buses
//   perf_cycles/stalls: present only when SPMV_SCHED_PERF_CNT_EN is defined
// Issue uses credits: a nonzero is accepted only if the FIFO has room for it
// counting products still inside the multiply pipeline, because the
// multiplier cannot stall.
module spmv_mul_scheduler
  import spmv_pkg::*;
#(
  parameter int COL_W      = 10,
  parameter int ROW_W      = 12,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] nnz_total,
  output logic             busy,
  output logic             done,
`ifdef SPMV_SCHED_PERF_CNT_EN
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls,
`endif
  spmv_mul_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 2;

  typedef struct packed {
    logic [FP16_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic              last;
  } prod_ent_t;

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              s1_valid_q, s1_valid_d;
  logic [FP16_W-1:0] s1_value_q, s1_value_d;
  logic [ROW_W-1:0]  s1_row_q, s1_row_d;
  logic              s1_last_q, s1_last_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ROW_W-1:0]  s2_row_q, s2_row_d;
  logic              s2_last_q, s2_last_d;

  logic              start_acc_s, nnz_ready_s, hs_s, pop_s;
  logic [1:0]        inflight_s;
  logic [OCC_W-1:0]  occ_s;
  logic              fifo_valid_s;
  logic [PTR_W:0]    fifo_count_s;
  prod_ent_t         push_ent_s, head_s;

  // Handshake qualification and credit check.
  always_comb begin
    start_acc_s = (state_q == IDLE) & start;
    inflight_s  = inflight_cnt(s1_valid_q, s2_valid_q);
    occ_s       = OCC_W'(fifo_count_s) + OCC_W'(inflight_s);
    nnz_ready_s = (state_q == RUN) & (issued_q < total_q) & (occ_s < OCC_W'(FIFO_DEPTH));
    hs_s        = bus.nnz_valid & nnz_ready_s;
    pop_s       = fifo_valid_s & bus.prod_ready;
    push_ent_s  = '{data: bus.mul_result, row: s2_row_q, last: s2_last_q};
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (issued_q == total_q) state_d = DRAIN;
        else                     state_d = RUN;
      end
      DRAIN: begin
        // Leave as the last product pops so done follows that pop directly.
        if ((inflight_s == 2'd0) &&
            ((fifo_count_s == (PTR_W+1)'(0)) ||
             ((fifo_count_s == (PTR_W+1)'(1)) && pop_s))) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass counters and the two multiply pipeline stages.
  always_comb begin
    total_d    = total_q;
    issued_d   = issued_q;
    row_d      = row_q;
    if (start_acc_s) begin
      total_d  = nnz_total;
      issued_d = '0;
      row_d    = '0;
    end else if (hs_s) begin
      issued_d = issued_q + CNT_W'(1);
      if (bus.nnz_last) row_d = row_q + ROW_W'(1);
      else              row_d = row_q;
    end else begin
      issued_d = issued_q;
      row_d    = row_q;
    end
    // Stage 1: operands captured on the handshake, vector word arrives next cycle.
    s1_valid_d = hs_s;
    s1_value_d = hs_s ? bus.nnz_value : 16'h0000;
    s1_row_d   = hs_s ? row_q : '0;
    s1_last_d  = hs_s & bus.nnz_last;
    // Stage 2: tag travels alongside the multiplier's registered result.
    s2_valid_d = s1_valid_q;
    s2_row_d   = s1_row_q;
    s2_last_d  = s1_last_q;
  end

  // Scheduler state registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      total_q    <= '0;
      issued_q   <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_value_q <= 16'h0000;
      s1_row_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_row_q   <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      row_q      <= row_d;
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_row_q   <= s1_row_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_row_q   <= s2_row_d;
      s2_last_q  <= s2_last_d;
    end
  end

  spmv_prod_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (prod_ent_t)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .clr    (start_acc_s),
    .push   (s2_valid_q),
    .din    (push_ent_s),
    .pop    (pop_s),
    .dout   (head_s),
    .valid  (fifo_valid_s),
    .count  (fifo_count_s)
  );

`ifdef SPMV_SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Activity and stall counters; they freeze outside a pass.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start_acc_s) begin
      perf_cycles_d = 32'd0;
      perf_stalls_d = 32'd0;
    end else begin
      if ((state_q == RUN) || (state_q == DRAIN)) perf_cycles_d = perf_cycles_q + 32'd1;
      else                                        perf_cycles_d = perf_cycles_q;
      if ((state_q == RUN) && bus.nnz_valid && !nnz_ready_s) perf_stalls_d = perf_stalls_q + 32'd1;
      else                                                   perf_stalls_d = perf_stalls_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

  assign busy            = (state_q == RUN) || (state_q == DRAIN);
  assign done            = (state_q == DONE);
  assign bus.nnz_ready   = nnz_ready_s;
  assign bus.vec_rd_en   = hs_s;
  assign bus.vec_rd_addr = hs_s ? bus.nnz_col : '0;
  assign bus.mul_vector  = s1_valid_q ? bus.vec_rd_data : 16'h0000;
  assign bus.mul_value   = s1_value_q;
  assign bus.prod_valid  = fifo_valid_s;
  assign bus.prod_data   = head_s.data;
  assign bus.prod_row    = head_s.row;
  assign bus.prod_last   = head_s.last;

endmodule

// File: tb/tb_spmv_mul_scheduler.sv
module tb_spmv_mul_scheduler;
  localparam int COL_W = 10;
  localparam int ROW_W = 12;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int MAXN  = 64;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] nnz_total = '0;
  logic             busy, done;
`ifdef SPMV_SCHED_PERF_CNT_EN
  logic [31:0]      perf_cycles, perf_stalls;
`endif

  spmv_mul_scheduler_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  spmv_mul_scheduler #(
    .COL_W(COL_W), .ROW_W(ROW_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .start     (start),
    .nnz_total (nnz_total),
    .busy      (busy),
    .done      (done),
`ifdef SPMV_SCHED_PERF_CNT_EN
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
`endif
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  // Stand-in multiplier: deterministic, with 1.0 acting as identity and zero annihilating.
  function automatic logic [15:0] fmul(input logic [15:0] v, input logic [15:0] a);
    logic [15:0] r;
    if (a == 16'h3C00)                           r = v;
    else if (v == 16'h3C00)                      r = a;
    else if (a[14:0] == 15'h0 || v[14:0] == 15'h0) r = 16'h0000;
    else                                         r = (v ^ {a[7:0], a[15:8]}) + 16'h1357;
    return r;
  endfunction

  logic [15:0] vram [1024];

  always @(posedge i_clk) begin
    if (bus.vec_rd_en) bus.vec_rd_data <= vram[bus.vec_rd_addr];
    bus.mul_result <= fmul(bus.mul_vector, bus.mul_value);
  end

  int errs = 0;
  int checks = 0;

  logic [15:0]      nz_val  [MAXN];
  logic [COL_W-1:0] nz_col  [MAXN];
  logic             nz_last [MAXN];
  logic [15:0]      ob_data [MAXN];
  logic [ROW_W-1:0] ob_row  [MAXN];
  logic             ob_last [MAXN];
  int ob_n, first_hs, first_pv, done_cyc, done_cnt, last_pop, addr_bad, vec_cnt;
  int extra_pv, hs_at_hold, timed_out;

  task automatic gen(input int n, input int last_pct, input int zero_pct);
    for (int i = 0; i < n; i++) begin
      nz_col[i]  = COL_W'($urandom_range(1023));
      nz_val[i]  = ($urandom_range(99) < zero_pct) ? 16'h0000 : 16'($urandom);
      nz_last[i] = ($urandom_range(99) < last_pct) || (i == n - 1);
    end
  endtask

  // Runs one pass: cycle 0 is the start cycle. Records observations only.
  task automatic run_pass(input int n, input int hold, input int rdy_pct, input int vld_pct,
                          input int restart_at);
    int di = 0;
    int cyc = 0;
    int post = 0;
    bit fin = 1'b0;
    bit pend = 1'b0;
    bit hs;
    ob_n = 0; first_hs = -1; first_pv = -1; done_cyc = -1; done_cnt = 0; last_pop = -1;
    addr_bad = 0; vec_cnt = 0; extra_pv = 0; hs_at_hold = -1; timed_out = 0;
    @(posedge i_clk); #1;
    while (!fin) begin
      if (cyc > 0) begin
        @(posedge i_clk); #1;
      end
      start     = (cyc == 0) || (cyc == restart_at);
      nnz_total = (cyc == 0) ? CNT_W'(n) : CNT_W'(n + 5);
      if (di < n && (pend || $urandom_range(99) < vld_pct)) begin
        bus.nnz_valid = 1'b1;
        bus.nnz_value = nz_val[di];
        bus.nnz_col   = nz_col[di];
        bus.nnz_last  = nz_last[di];
      end else begin
        bus.nnz_valid = 1'b0;
        bus.nnz_value = 16'h0000;
        bus.nnz_col   = '0;
        bus.nnz_last  = 1'b0;
      end
      bus.prod_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      @(negedge i_clk);
      hs = bus.nnz_valid && bus.nnz_ready;
      if (hs) begin
        if (bus.vec_rd_addr !== nz_col[di] || bus.vec_rd_en !== 1'b1) addr_bad++;
        if (first_hs < 0) first_hs = cyc;
        di++;
      end
      pend = bus.nnz_valid && !hs;
      if (bus.vec_rd_en) vec_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.prod_valid) begin
        if (first_pv < 0) first_pv = cyc;
        if (done_cyc >= 0) extra_pv++;
        if (bus.prod_ready) begin
          if (ob_n < MAXN) begin
            ob_data[ob_n] = bus.prod_data;
            ob_row[ob_n]  = bus.prod_row;
            ob_last[ob_n] = bus.prod_last;
          end
          ob_n++;
          last_pop = cyc;
        end
      end
      if (cyc == hold - 1) hs_at_hold = di;
      if (done_cyc >= 0) post++;
      if (post > 3) fin = 1'b1;
      if (cyc > 3000) begin
        timed_out = 1;
        fin = 1'b1;
      end
      cyc++;
    end
    start = 1'b0;
    bus.nnz_valid = 1'b0;
    bus.prod_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.nnz_valid = 1'b1; bus.nnz_value = 16'h3C00; bus.nnz_col = '0; bus.nnz_last = 1'b0;
    bus.prod_ready = 1'b1;
    #12;
    checks++;
    if ({busy, done, bus.nnz_ready, bus.vec_rd_en, bus.prod_valid} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bus.nnz_ready, bus.vec_rd_en, bus.prod_valid});
    end
    checks++;
    if ({bus.prod_data, bus.prod_row, bus.prod_last} !== 29'h0) begin
      errs++; $display("FAIL reset_prod: got %h want 0", {bus.prod_data, bus.prod_row, bus.prod_last});
    end
    checks++;
    if ({bus.mul_vector, bus.mul_value} !== 32'h0) begin
      errs++; $display("FAIL reset_mul: got %h want 0", {bus.mul_vector, bus.mul_value});
    end
    @(negedge i_clk); i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({busy, bus.nnz_ready, bus.vec_rd_en, bus.mul_value} !== 19'h0) begin
      errs++; $display("FAIL idle_ignore_valid: got %h want 0", {busy, bus.nnz_ready, bus.vec_rd_en, bus.mul_value});
    end
    bus.nnz_valid = 1'b0; bus.prod_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [3] = '{16'h4000, 16'h4000, 16'h4000};
    logic [ROW_W-1:0] exp_r [3] = '{12'd0, 12'd0, 12'd1};
    logic exp_l [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      nz_col[i] = COL_W'(10 + i); nz_val[i] = 16'h3C00; vram[10 + i] = 16'h4000;
    end
    nz_last[0] = 1'b0; nz_last[1] = 1'b1; nz_last[2] = 1'b1;
    run_pass(3, 0, 100, 100, -1);
    checks++;
    if (timed_out !== 0 || ob_n !== 3) begin
      errs++; $display("FAIL basic_count: got %0d products (timeout=%0d) want 3", ob_n, timed_out);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ob_data[i] !== exp_d[i] || ob_row[i] !== exp_r[i] || ob_last[i] !== exp_l[i]) begin
        errs++; $display("FAIL basic_prod[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                         ob_data[i], ob_row[i], ob_last[i], exp_d[i], exp_r[i], exp_l[i]);
      end
    end
    checks++;
    if (first_pv - first_hs !== 3) begin
      errs++; $display("FAIL basic_latency: got %0d want 3", first_pv - first_hs);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc - last_pop !== 1) begin
      errs++; $display("FAIL basic_done: got cnt=%0d gap=%0d want cnt=1 gap=1", done_cnt, done_cyc - last_pop);
    end
    checks++;
    if (addr_bad !== 0 || extra_pv !== 0) begin
      errs++; $display("FAIL basic_addr: got bad=%0d extra=%0d want 0/0", addr_bad, extra_pv);
    end
  endtask

  task automatic test_backpressure();
    logic [ROW_W-1:0] row = '0;
    gen(10, 30, 0);
    run_pass(10, 20, 100, 100, -1);
    checks++;
    if (hs_at_hold !== DEPTH) begin
      errs++; $display("FAIL bp_credit: got %0d accepted want %0d", hs_at_hold, DEPTH);
    end
    checks++;
    if (timed_out !== 0 || ob_n !== 10 || done_cnt !== 1) begin
      errs++; $display("FAIL bp_count: got n=%0d done=%0d to=%0d want 10/1/0", ob_n, done_cnt, timed_out);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ob_data[i] !== fmul(vram[nz_col[i]], nz_val[i]) || ob_row[i] !== row || ob_last[i] !== nz_last[i]) begin
        errs++; $display("FAIL bp_prod[%0d]: got %h/%0d/%b want %h/%0d/%b", i, ob_data[i], ob_row[i],
                         ob_last[i], fmul(vram[nz_col[i]], nz_val[i]), row, nz_last[i]);
      end
      if (nz_last[i]) row = row + 12'd1;
    end
  endtask

  task automatic test_zero_pass();
    run_pass(0, 0, 100, 100, -1);
    checks++;
    if (done_cyc !== 3 || done_cnt !== 1) begin
      errs++; $display("FAIL zero_done: got cyc=%0d cnt=%0d want 3/1", done_cyc, done_cnt);
    end
    checks++;
    if (vec_cnt !== 0 || first_pv !== -1) begin
      errs++; $display("FAIL zero_quiet: got rd=%0d pv=%0d want 0/-1", vec_cnt, first_pv);
    end
  endtask

  task automatic test_random(input int n, input int zero_pct, input string tag);
    logic [ROW_W-1:0] row = '0;
    gen(n, 30, zero_pct);
    run_pass(n, 0, 65, 70, -1);
    checks++;
    if (timed_out !== 0 || ob_n !== n || done_cnt !== 1 || addr_bad !== 0) begin
      errs++; $display("FAIL %s_count: got n=%0d done=%0d bad=%0d to=%0d want %0d/1/0/0", tag,
                       ob_n, done_cnt, addr_bad, timed_out, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ob_data[i] !== fmul(vram[nz_col[i]], nz_val[i]) || ob_row[i] !== row || ob_last[i] !== nz_last[i]) begin
        errs++; $display("FAIL %s_prod[%0d]: got %h/%0d/%b want %h/%0d/%b", tag, i, ob_data[i], ob_row[i],
                         ob_last[i], fmul(vram[nz_col[i]], nz_val[i]), row, nz_last[i]);
      end
      if (nz_last[i]) row = row + 12'd1;
    end
  endtask

  task automatic test_zero_value();
    gen(4, 50, 100);
    nz_last[0] = 1'b1;
    run_pass(4, 0, 100, 100, -1);
    checks++;
    if (ob_n !== 4 || timed_out !== 0) begin
      errs++; $display("FAIL zval_count: got %0d want 4", ob_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ob_data[i] !== 16'h0000 || (i == 1 && ob_row[i] !== 12'd1)) begin
        errs++; $display("FAIL zval_prod[%0d]: got %h/%0d want 0000 (row 1 at index 1)", i, ob_data[i], ob_row[i]);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int hs = 0;
    int cyc = 0;
    logic [ROW_W-1:0] row = '0;
    gen(6, 60, 0);
    @(posedge i_clk); #1;
    start = 1'b1; nnz_total = 16'd6; bus.prod_ready = 1'b1;
    bus.nnz_valid = 1'b1; bus.nnz_value = nz_val[0]; bus.nnz_col = nz_col[0]; bus.nnz_last = nz_last[0];
    while (hs < 2 && cyc < 50) begin
      @(negedge i_clk);
      if (bus.nnz_valid && bus.nnz_ready) hs++;
      @(posedge i_clk); #1;
      start = 1'b0;
      bus.nnz_value = nz_val[hs]; bus.nnz_col = nz_col[hs]; bus.nnz_last = nz_last[hs];
      cyc++;
    end
    checks++;
    if (hs !== 2) begin
      errs++; $display("FAIL rstmid_setup: got %0d handshakes want 2", hs);
    end
    #1 i_rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.nnz_ready, bus.vec_rd_en, bus.prod_valid, bus.prod_data, bus.prod_row,
         bus.prod_last, bus.mul_vector, bus.mul_value} !== 66'h0) begin
      errs++; $display("FAIL rstmid_outputs: got %h want 0", {busy, done, bus.nnz_ready, bus.vec_rd_en,
                       bus.prod_valid, bus.prod_data, bus.prod_row, bus.prod_last, bus.mul_vector, bus.mul_value});
    end
    bus.nnz_valid = 1'b0;
    @(negedge i_clk); i_rstn = 1'b1;
    repeat (4) @(negedge i_clk);
    checks++;
    if (bus.prod_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_stale: got pv=%b busy=%b want 0/0", bus.prod_valid, busy);
    end
    gen(3, 50, 0);
    run_pass(3, 0, 100, 100, -1);
    checks++;
    if (ob_n !== 3 || timed_out !== 0) begin
      errs++; $display("FAIL rstmid_count: got %0d want 3", ob_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ob_data[i] !== fmul(vram[nz_col[i]], nz_val[i]) || ob_row[i] !== row) begin
        errs++; $display("FAIL rstmid_prod[%0d]: got %h/%0d want %h/%0d", i, ob_data[i], ob_row[i],
                         fmul(vram[nz_col[i]], nz_val[i]), row);
      end
      if (nz_last[i]) row = row + 12'd1;
    end
  endtask

  task automatic test_start_during_run();
    logic [ROW_W-1:0] row = '0;
    gen(8, 40, 0);
    run_pass(8, 0, 60, 80, 5);
    checks++;
    if (ob_n !== 8 || done_cnt !== 1 || timed_out !== 0) begin
      errs++; $display("FAIL restart_count: got n=%0d done=%0d to=%0d want 8/1/0", ob_n, done_cnt, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ob_data[i] !== fmul(vram[nz_col[i]], nz_val[i]) || ob_row[i] !== row || ob_last[i] !== nz_last[i]) begin
        errs++; $display("FAIL restart_prod[%0d]: got %h/%0d/%b want %h/%0d/%b", i, ob_data[i], ob_row[i],
                         ob_last[i], fmul(vram[nz_col[i]], nz_val[i]), row, nz_last[i]);
      end
      if (nz_last[i]) row = row + 12'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 16'($urandom);
    bus.nnz_valid = 1'b0; bus.nnz_value = 16'h0000; bus.nnz_col = '0; bus.nnz_last = 1'b0;
    bus.prod_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_pass();
    test_zero_value();
    test_random(40, 20, "rand");
    test_random(12, 0, "b2b");
    test_reset_midpass();
    test_start_during_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spmv_mul_scheduler.md
# spmv_mul_scheduler

Sequencing controller for the fp16 SpMV multiplier. Accepts a CSR-ordered stream of nonzeros (value, column index, end-of-row flag), fetches the matching dense-vector element from a synchronous-read vector RAM, drives the operands into the one-cycle fp16 multiplier, and buffers the tagged products for the downstream row accumulator. Credit-based issue guarantees no product is lost under output back-pressure, even though the multiplier itself cannot stall.

## Interface
Parameters:
- COL_W, 10, vector RAM address / column-index width
- ROW_W, 12, row-tag width
- CNT_W, 16, nonzero-count width
- FIFO_DEPTH, 4, product buffer entries (power of two, ≥ 4)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous active-low reset
- start  in  1  begin a matrix pass (sampled only in IDLE)
- nnz_total  in  CNT_W  nonzeros in this pass, sampled with start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when pass completes
- nnz_valid  in  1  nonzero available
- nnz_ready  out  1  scheduler accepts nonzero
- nnz_value  in  16  fp16 matrix value
- nnz_col  in  COL_W  column index
- nnz_last  in  1  last nonzero of current row
- vec_rd_en  out  1  vector RAM read strobe
- vec_rd_addr  out  COL_W  vector RAM address
- vec_rd_data  in  16  fp16 vector element, valid cycle after vec_rd_en
- mul_vector  out  16  multiplier vector operand
- mul_value  out  16  multiplier value operand
- mul_result  in  16  multiplier result, registered by multiplier
- prod_valid  out  1  product available
- prod_ready  in  1  downstream accepts product
- prod_data  out  16  fp16 product
- prod_row  out  ROW_W  row index of product
- prod_last  out  1  product closes its row

## Operation
- FSM: IDLE → (start) RUN → (issued == nnz_total) DRAIN → (in-flight == 0 and FIFO empty) DONE → IDLE. DONE lasts one cycle, asserts done.
- start with nnz_total == 0: IDLE → RUN → DRAIN → DONE, no nonzeros accepted, no products emitted.
- start outside IDLE ignored. nnz_valid outside RUN ignored (nnz_ready = 0).
- On start: issued count, row counter, FIFO cleared to 0.
- nnz_ready = (state == RUN) & (issued < nnz_total) & (fifo_count + inflight < FIFO_DEPTH); inflight = 0..2 pipeline stages occupied.
- Row counter: tags each accepted nonzero, increments after acceptance of a nonzero with nnz_last = 1; wraps modulo 2^ROW_W.
- Products pass unmodified (zero, x, overflow from multiplier are not interpreted).
- prod_* driven from FIFO head; pop on prod_valid & prod_ready. Push and pop in same cycle legal at any occupancy.
- Outputs in IDLE: mul_vector/mul_value = 0.

## Timing
- Cycle T: nnz handshake; vec_rd_en = 1, vec_rd_addr = nnz_col; value, row tag, last captured in stage-1 register.
- T+1: mul_vector = vec_rd_data, mul_value = stage-1 value; multiplier samples at end of T+1.
- T+2: mul_result valid; pushed into FIFO with tag and last. Earliest prod_valid in T+3 (registered FIFO output).
- Throughput one nonzero per cycle while prod_ready held high.
- done asserted the cycle after last product is popped and pipeline empty.
- Reset (any time, including mid-pass): state IDLE, busy/done/nnz_ready/vec_rd_en/prod_valid = 0, prod_data/prod_row/prod_last = 0, counters and FIFO cleared; in-flight products discarded.

## Configuration
- SPMV_SCHED_PERF_CNT_EN: when defined, adds outputs perf_cycles (32) counting cycles in RUN and DRAIN, and perf_stalls (32) counting RUN cycles with nnz_valid = 1 and nnz_ready = 0; both clear on start, hold after done, reset 0. When undefined, ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package spmv_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), fp16 width constant (16), product-entry struct {data, row, last}.
- One sub-module: spmv_prod_fifo (synchronous FIFO, FIFO_DEPTH entries, count output). Multiplier instantiated outside; scheduler connects via mul_* ports.

## Test plan
- nnz_total = 3, rows {2 nnz, 1 nnz}, value 0x3C00 (1.0) × vector 0x4000 (2.0), prod_ready = 1 → three products 0x4000, rows 0,0,1, last 0,1,1; first prod_valid 3 cycles after first handshake; done once.
- prod_ready = 0 for 20 cycles, nnz_total = 10 continuous → nnz_ready drops after FIFO_DEPTH accepted; release → all 10 products in order, none lost or duplicated.
- start with nnz_total = 0 → done pulse within 3 cycles, no vec_rd_en, no prod_valid.
- value exponent 0 (0x0000) → prod_data 0x0000 passed through, row tag correct.
- i_rstn low mid-pass with 2 products in flight → all outputs 0 immediately; after release new pass starts at row 0 with no stale products.
- start asserted during RUN → ignored, nnz_total and counters unchanged.
